// File: rtl/morningjava_hex_scroller.sv
// morningjava_hex_scroller: accepts a word over valid/ready and shows its hex digits MSB first, each held for a dwell period and then a blank gap.
// Define MORNINGJAVA_ZERO_BLANK_EN to skip leading zero nibbles.
module morningjava_hex_scroller #(
  parameter int NIBBLES      = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic [3:0]           digit,
  output logic                 digit_on,
  output logic                 dp,
  output logic                 busy
);
  localparam int MAXC = DWELL_CYCLES > GAP_CYCLES ? DWELL_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  state_t r_state;
  logic [TW-1:0] r_timer;
  logic [IW-1:0] r_idx, w_start, w_idx_dn;
  logic [4*NIBBLES-1:0] r_word;
  logic w_take;
  assign w_take = in_valid & in_ready;
  assign w_idx_dn = r_idx - 1'b1;
  assign busy = r_state != IDLE;
`ifdef MORNINGJAVA_ZERO_BLANK_EN
  // Highest nonzero nibble; an all-zero word falls back to nibble 0.
  always_comb begin
    w_start = '0;
    for (int i = 1; i < NIBBLES; i++) if (in_data[4*i +: 4] != 4'h0) w_start = IW'(i);
  end
`else
  assign w_start = IW'(NIBBLES - 1);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      in_ready <= 1'b0;
      digit    <= 4'h0;
      digit_on <= 1'b0;
      dp       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_word   <= in_data;
            r_idx    <= w_start;
            r_timer  <= DWELL_LD;
            r_state  <= SHOW;
            in_ready <= 1'b0;
            digit    <= in_data[4*w_start +: 4];
            digit_on <= 1'b1;
            dp       <= w_start == '0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHOW: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else begin
            r_timer  <= GAP_LD;
            r_state  <= GAP;
            digit_on <= 1'b0;
            dp       <= 1'b0;
          end
        end
        GAP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (r_idx != '0) begin
            r_idx    <= w_idx_dn;
            r_timer  <= DWELL_LD;
            r_state  <= SHOW;
            digit    <= r_word[4*w_idx_dn +: 4];
            digit_on <= 1'b1;
            dp       <= w_idx_dn == '0;
          end else begin
            r_state  <= IDLE;
            in_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
